// File: rtl/btn_pkg.sv
// Shared types and default timing for the button press generator and the btn_count benches.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE,
        HOLD,
        GAP,
        DONE
    } btn_gen_state_t;

    localparam int DEF_BOUNCE_EDGES = 2;
    localparam int DEF_PRESS_CYCLES = 4;
    localparam int DEF_GAP_CYCLES   = 4;
    localparam int DEF_CNT_W        = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width able to hold max_dur-1, never below one bit.
    function automatic int timer_width(input int max_dur);
        return (max_dur < 2) ? 1 : $clog2(max_dur);
    endfunction

endpackage

// File: rtl/btn_phase_timer.sv
// Loadable down-counter that times one FSM phase; expired is high on the phase's last cycle.
module btn_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/btn_press_gen.sv
// Button-press stimulus source: emits num_press presses of bounce, hold and gap on a registered btn line.
module btn_press_gen
    import btn_pkg::*;
#(
    parameter int BOUNCE_EDGES = DEF_BOUNCE_EDGES,
    parameter int PRESS_CYCLES = DEF_PRESS_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_press,
    input  logic             abort,
    output logic             btn,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] presses_sent
);

    localparam int MAX_DUR = max3(2 * BOUNCE_EDGES, PRESS_CYCLES, GAP_CYCLES);
    localparam int TW      = timer_width(MAX_DUR);

    localparam logic [TW-1:0] BOUNCE_LOAD = TW'((BOUNCE_EDGES > 0) ? 2 * BOUNCE_EDGES - 1 : 0);
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_CYCLES - 1);

    localparam btn_gen_state_t PRESS_ENTRY = (BOUNCE_EDGES > 0) ? BOUNCE : HOLD;

    btn_gen_state_t   state;
    btn_gen_state_t   state_next;
    logic             start_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] remaining;
    logic             load;
    logic [TW-1:0]    load_val;
    logic             expired;
    logic             btn_next;
    logic             accept;

    btn_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    // The request is registered first so the outputs, which follow the state, start one edge later.
    assign accept = start && (state == IDLE) && !start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            num_q   <= '0;
        end else begin
            start_q <= accept;
            if (accept) begin
                num_q <= num_press;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            btn   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            btn   <= btn_next;
            busy  <= (state_next inside {BOUNCE, HOLD, GAP});
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining    <= '0;
            presses_sent <= '0;
        end else if (state == IDLE && start_q && num_q != '0) begin
            remaining    <= num_q;
            presses_sent <= '0;
        end else if (state == HOLD && expired && !abort) begin
            remaining    <= remaining - 1'b1;
            presses_sent <= presses_sent + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_val   = '0;
        btn_next   = 1'b0;

        case (state)
            IDLE: begin
                if (start_q) begin
                    state_next = (num_q != '0) ? PRESS_ENTRY : DONE;
                end
            end
            BOUNCE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (expired) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (expired) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (expired) begin
                    state_next = (remaining != '0) ? PRESS_ENTRY : DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Every state change is a phase entry, so the timer reloads exactly then.
        load = (state_next != state);

        case (state_next)
            BOUNCE: begin
                load_val = BOUNCE_LOAD;
                btn_next = (state == BOUNCE) ? ~btn : 1'b1;
            end
            HOLD: begin
                load_val = HOLD_LOAD;
                btn_next = 1'b1;
            end
            GAP: begin
                load_val = GAP_LOAD;
            end
            default: begin
                load_val = '0;
            end
        endcase
    end

endmodule
